// File: rtl/mainfsm.sv
// Multicycle main control FSM: walks each instruction through fetch/decode/execute/memory/writeback,
// drives datapath selects and enables, handshakes with variable-latency memory, counts retirements.
module mainfsm #(
  parameter bit ENABLE_UTYPE = 1'b1,
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [6:0]              OP,
  input  logic                    MEM_READY,
  output logic                    MEM_REQ,
  output logic                    ADR_SRC,
  output logic                    MEM_WRITE,
  output logic                    IR_WRITE,
  output logic                    PC_UPDATE,
  output logic                    BRANCH,
  output logic                    REG_WRITE,
  output logic [1:0]              ALU_SRC_A,
  output logic [1:0]              ALU_SRC_B,
  output logic [1:0]              ALU_OP,
  output logic [1:0]              RESULT_SRC,
  output logic [2:0]              IMM_SRC,
  output logic                    ILLEGAL,
  output logic                    RETIRE,
  output logic [RETIRE_CNT_W-1:0] RETIRE_CNT
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_UTYPE    = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  state_e                  state_q, state_d;
  logic [RETIRE_CNT_W-1:0] cnt_q, cnt_d;

  logic       mem_req_s, adr_src_s, mem_write_s, ir_write_s, pc_update_s;
  logic       branch_s, reg_write_s, illegal_s, retire_s;
  logic [1:0] alu_src_a_s, alu_src_b_s, alu_op_s, result_src_s;
  logic [2:0] imm_src_s;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_FETCH;
      cnt_q   <= {RETIRE_CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = MEM_READY ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (OP)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_R:             state_d = S_EXECR;
          OP_I:             state_d = S_EXECI;
          OP_BEQ:           state_d = S_BEQ;
          OP_JAL:           state_d = S_JAL;
          OP_LUI, OP_AUIPC: state_d = ENABLE_UTYPE ? S_UTYPE : S_TRAP;
          default:          state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (OP == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = MEM_READY ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = MEM_READY ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_UTYPE:    state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
    // counter wraps silently; TRAP never raises RETIRE so it stays frozen there
    cnt_d = retire_s ? (cnt_q + RETIRE_CNT_W'(1)) : cnt_q;
  end

  always_comb begin
    mem_req_s    = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    reg_write_s  = 1'b0;
    illegal_s    = 1'b0;
    retire_s     = 1'b0;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    result_src_s = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req_s    = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = MEM_READY;
        pc_update_s  = MEM_READY;
      end
      S_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
      end
      S_MEMREAD: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_s   = 1'b1;
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        retire_s    = MEM_READY;
      end
      S_EXECR: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b10;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b01;
        branch_s    = 1'b1;
        retire_s    = 1'b1;
      end
      S_JAL: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_update_s = 1'b1;
      end
      S_UTYPE: begin
        alu_src_a_s = (OP == OP_LUI) ? 2'b11 : 2'b01;
        alu_src_b_s = 2'b01;
      end
      S_TRAP:  illegal_s = 1'b1;
      default: illegal_s = 1'b0;
    endcase
    case (OP)
      OP_LW, OP_I:      imm_src_s = 3'b000;
      OP_SW:            imm_src_s = 3'b001;
      OP_BEQ:           imm_src_s = 3'b010;
      OP_JAL:           imm_src_s = 3'b011;
      OP_LUI, OP_AUIPC: imm_src_s = ENABLE_UTYPE ? 3'b100 : 3'b000;
      default:          imm_src_s = 3'b000;
    endcase
  end

  // enables are held off for the whole reset pulse, not just until the state flop clears
  assign MEM_REQ    = mem_req_s   & ~RESET;
  assign IR_WRITE   = ir_write_s  & ~RESET;
  assign PC_UPDATE  = pc_update_s & ~RESET;
  assign MEM_WRITE  = mem_write_s & ~RESET;
  assign REG_WRITE  = reg_write_s & ~RESET;
  assign BRANCH     = branch_s    & ~RESET;
  assign RETIRE     = retire_s    & ~RESET;
  assign ADR_SRC    = adr_src_s;
  assign ALU_SRC_A  = alu_src_a_s;
  assign ALU_SRC_B  = alu_src_b_s;
  assign ALU_OP     = alu_op_s;
  assign RESULT_SRC = result_src_s;
  assign IMM_SRC    = imm_src_s;
  assign ILLEGAL    = illegal_s;
  assign RETIRE_CNT = cnt_q;

endmodule

// File: tb/tb_mainfsm.sv
// Scoreboard bench for mainfsm: a memory/IR responder feeds opcodes, a monitor checks each
// retired or trapped instruction against a per-instruction summary computed from the opcode rules.
module tb_mainfsm;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct {
    bit          trap;
    int          cycles, irw_at, memreq, adr1, memwr, rw_cnt, rw_at, branch, pcu, a11;
    logic [1:0]  rs, aop;
    logic [2:0]  imm;
    logic [31:0] cnt;
  } exp_t;

  logic       CLK = 1'b0;
  logic       rst1 = 1'b1, rst2 = 1'b1, sel = 1'b0;
  logic [6:0] OP = 7'b0000000;
  logic       MEM_READY = 1'b0;

  logic        m1_req, m1_adr, m1_mw, m1_irw, m1_pcu, m1_br, m1_rw, m1_ill, m1_ret;
  logic [1:0]  m1_a, m1_b, m1_aop, m1_rs;
  logic [2:0]  m1_imm;
  logic [31:0] m1_cnt;
  logic        m2_req, m2_adr, m2_mw, m2_irw, m2_pcu, m2_br, m2_rw, m2_ill, m2_ret;
  logic [1:0]  m2_a, m2_b, m2_aop, m2_rs;
  logic [2:0]  m2_imm;
  logic [2:0]  m2_cnt;

  logic [19:0] s_out;
  logic [31:0] s_cnt;
  logic        s_rst, s_req, s_adr, s_mw, s_irw, s_pcu, s_br, s_rw, s_ill, s_ret;
  logic [1:0]  s_a, s_b, s_aop, s_rs;
  logic [2:0]  s_imm;

  exp_t       exp_q[$];
  int         wait_q[$];
  logic [6:0] prog_q[$];
  int checks = 0, errors = 0, n_issued = 0;

  always #5 CLK = ~CLK;

  mainfsm dut1 (
    .CLK(CLK), .RESET(rst1), .OP(OP), .MEM_READY(MEM_READY),
    .MEM_REQ(m1_req), .ADR_SRC(m1_adr), .MEM_WRITE(m1_mw), .IR_WRITE(m1_irw),
    .PC_UPDATE(m1_pcu), .BRANCH(m1_br), .REG_WRITE(m1_rw), .ALU_SRC_A(m1_a),
    .ALU_SRC_B(m1_b), .ALU_OP(m1_aop), .RESULT_SRC(m1_rs), .IMM_SRC(m1_imm),
    .ILLEGAL(m1_ill), .RETIRE(m1_ret), .RETIRE_CNT(m1_cnt)
  );

  mainfsm #(.ENABLE_UTYPE(1'b0), .RETIRE_CNT_W(3)) dut2 (
    .CLK(CLK), .RESET(rst2), .OP(OP), .MEM_READY(MEM_READY),
    .MEM_REQ(m2_req), .ADR_SRC(m2_adr), .MEM_WRITE(m2_mw), .IR_WRITE(m2_irw),
    .PC_UPDATE(m2_pcu), .BRANCH(m2_br), .REG_WRITE(m2_rw), .ALU_SRC_A(m2_a),
    .ALU_SRC_B(m2_b), .ALU_OP(m2_aop), .RESULT_SRC(m2_rs), .IMM_SRC(m2_imm),
    .ILLEGAL(m2_ill), .RETIRE(m2_ret), .RETIRE_CNT(m2_cnt)
  );

  assign s_out = sel ? {m2_req, m2_adr, m2_mw, m2_irw, m2_pcu, m2_br, m2_rw, m2_a, m2_b, m2_aop, m2_rs, m2_imm, m2_ill, m2_ret}
                     : {m1_req, m1_adr, m1_mw, m1_irw, m1_pcu, m1_br, m1_rw, m1_a, m1_b, m1_aop, m1_rs, m1_imm, m1_ill, m1_ret};
  assign {s_req, s_adr, s_mw, s_irw, s_pcu, s_br, s_rw, s_a, s_b, s_aop, s_rs, s_imm, s_ill, s_ret} = s_out;
  assign s_cnt = sel ? {29'd0, m2_cnt} : m1_cnt;
  assign s_rst = sel ? rst2 : rst1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 lui, 7 auipc, 8 illegal
  function automatic int kind(input logic [6:0] op, input bit en_u);
    case (op)
      OP_LW:    return 0;
      OP_SW:    return 1;
      OP_R:     return 2;
      OP_I:     return 3;
      OP_BEQ:   return 4;
      OP_JAL:   return 5;
      OP_LUI:   return en_u ? 6 : 8;
      OP_AUIPC: return en_u ? 7 : 8;
      default:  return 8;
    endcase
  endfunction

  function automatic exp_t make_exp(input logic [6:0] op, input int fw, input int mw,
                                    input bit en_u, input logic [31:0] cnt);
    exp_t e;
    int k = kind(op, en_u);
    bit memop = (k <= 1);
    int base = (k == 0) ? 5 : ((k == 4 || k == 8) ? 3 : 4);
    e = '{default: 0};
    e.trap   = (k == 8);
    e.cycles = base + fw + (memop ? mw : 0);
    e.irw_at = fw + 1;
    e.memreq = fw + 1 + (memop ? mw + 1 : 0);
    e.adr1   = memop ? mw + 1 : 0;
    e.memwr  = (k == 1) ? mw + 1 : 0;
    e.rw_cnt = (k == 0 || k == 2 || k == 3 || k == 5 || k == 6 || k == 7) ? 1 : 0;
    e.rw_at  = (e.rw_cnt == 1) ? e.cycles : 0;
    e.branch = (k == 4) ? 1 : 0;
    e.pcu    = (k == 5) ? 2 : 1;
    e.a11    = (k == 6) ? 1 : 0;
    e.rs     = (k == 0) ? 2'b01 : 2'b00;
    e.aop    = (k == 4) ? 2'b01 : 2'b00;
    case (k)
      1:       e.imm = 3'b001;
      4:       e.imm = 3'b010;
      5:       e.imm = 3'b011;
      6, 7:    e.imm = 3'b100;
      default: e.imm = 3'b000;
    endcase
    e.cnt = cnt;
    return e;
  endfunction

  task automatic issue(input logic [6:0] op, input int fw, input int mw);
    bit en_u = !sel;
    logic [31:0] mask = sel ? 32'd7 : 32'hFFFF_FFFF;
    exp_t e;
    int k = kind(op, en_u);
    if (k != 8) n_issued++;
    e = make_exp(op, fw, mw, en_u, n_issued & mask);
    exp_q.push_back(e);
    wait_q.push_back(fw);
    if (k <= 1) wait_q.push_back(mw);
    prog_q.push_back(op);
  endtask

  task automatic flush();
    exp_q.delete();
    wait_q.delete();
    prog_q.delete();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
    if (exp_q.size() > 0) flush();
    repeat (2) begin @(posedge CLK); #1; end
  endtask

  task automatic do_reset(input logic s);
    @(posedge CLK); #1;
    rst1 = 1'b1;
    rst2 = 1'b1;
    flush();
    n_issued = 0;
    repeat (2) begin @(posedge CLK); #1; end
    sel = s;
    if (s) rst2 = 1'b0;
    else   rst1 = 1'b0;
  endtask

  // memory + instruction register model: stalls fetch while no program is queued
  int wcnt = 0;
  always @(negedge CLK) begin
    if (s_rst) begin
      MEM_READY = 1'b0;
      wcnt = 0;
    end else if (s_req) begin
      if (!s_adr && prog_q.size() == 0) begin
        MEM_READY = 1'b0;
      end else if (wcnt >= ((wait_q.size() > 0) ? wait_q[0] : 0)) begin
        MEM_READY = 1'b1;
        wcnt = 0;
        if (wait_q.size() > 0) void'(wait_q.pop_front());
        if (!s_adr) OP = prog_q.pop_front();
      end else begin
        MEM_READY = 1'b0;
        wcnt++;
      end
    end else begin
      MEM_READY = 1'($urandom_range(0, 1));
      wcnt = 0;
    end
  end

  int idx, a_irw_cnt, a_irw_at, a_memreq, a_adr1, a_memwr, a_rw_cnt, a_rw_at, a_branch, a_pcu, a_a11;
  bit in_trap = 0, cnt_pend = 0;
  logic [31:0] cnt_exp;

  task automatic clr_acc();
    idx = 0; a_irw_cnt = 0; a_irw_at = 0; a_memreq = 0; a_adr1 = 0; a_memwr = 0;
    a_rw_cnt = 0; a_rw_at = 0; a_branch = 0; a_pcu = 0; a_a11 = 0;
  endtask

  initial clr_acc();

  always @(negedge CLK) begin
    exp_t e;
    #2;
    if (s_rst) begin
      chk("rst_enables", {s_req, s_irw, s_pcu, s_mw, s_rw, s_ret}, 0);
      chk("rst_cnt", s_cnt, 0);
      chk("rst_illegal", s_ill, 0);
      clr_acc();
      in_trap = 0;
      cnt_pend = 0;
    end else begin
      chk("no_x", $isunknown({s_out, s_cnt}), 0);
      if (cnt_pend) begin
        chk("retire_cnt", s_cnt, cnt_exp);
        cnt_pend = 0;
      end
      if (in_trap) begin
        chk("trap_hold", {s_req, s_ill, s_ret}, 3'b010);
      end else if (exp_q.size() > 0) begin
        idx++;
        if (s_irw) begin a_irw_cnt++; a_irw_at = idx; end
        if (s_req) a_memreq++;
        if (s_req && s_adr) a_adr1++;
        if (s_mw) a_memwr++;
        if (s_rw) begin a_rw_cnt++; a_rw_at = idx; end
        if (s_br) a_branch++;
        if (s_pcu) a_pcu++;
        if (s_a == 2'b11) a_a11++;
        if (s_ill) begin
          e = exp_q.pop_front();
          chk("trap_expected", e.trap, 1);
          chk("trap_cycle", idx, e.cycles);
          in_trap = 1;
          clr_acc();
        end else if (s_ret) begin
          e = exp_q.pop_front();
          chk("retire_expected", e.trap, 0);
          chk("cycles", idx, e.cycles);
          chk("ir_write_at", a_irw_at, e.irw_at);
          chk("ir_write_cnt", a_irw_cnt, 1);
          chk("mem_req_cycles", a_memreq, e.memreq);
          chk("adr_src1_cycles", a_adr1, e.adr1);
          chk("mem_write_cycles", a_memwr, e.memwr);
          chk("reg_write_cnt", a_rw_cnt, e.rw_cnt);
          chk("reg_write_at", a_rw_at, e.rw_at);
          chk("branch_cycles", a_branch, e.branch);
          chk("pc_update_cycles", a_pcu, e.pcu);
          chk("alu_a11_cycles", a_a11, e.a11);
          chk("result_src_retire", s_rs, e.rs);
          chk("alu_op_retire", s_aop, e.aop);
          chk("imm_src", s_imm, e.imm);
          cnt_exp = e.cnt;
          cnt_pend = 1;
          clr_acc();
        end
      end else begin
        chk("idle_quiet", {s_ret, s_rw, s_mw, s_irw, s_ill, s_br}, 0);
      end
    end
  end

  initial begin
    logic [6:0] legal [8];
    legal = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_LUI, OP_AUIPC};
    repeat (3) @(posedge CLK);
    #1 rst1 = 1'b0;
    issue(OP_R, 0, 0);       drain();
    issue(OP_LW, 2, 3);      drain();
    issue(OP_SW, 0, 1);      drain();
    issue(OP_BEQ, 0, 0);
    issue(OP_JAL, 0, 0);     drain();
    issue(OP_LUI, 0, 0);
    issue(OP_AUIPC, 1, 0);
    issue(OP_I, 0, 0);       drain();
    for (int i = 0; i < 40; i++)
      issue(legal[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3));
    drain();
    // reset in the middle of a long MEMREAD wait
    issue(OP_LW, 0, 30);
    repeat (6) @(posedge CLK);
    do_reset(1'b0);
    issue(OP_R, 0, 0);       drain();
    issue(7'b1111111, 0, 0); drain();
    repeat (10) @(posedge CLK);
    do_reset(1'b1);
    // narrow counter, U-type disabled
    for (int i = 0; i < 9; i++) issue(OP_R, $urandom_range(0, 2), 0);
    drain();
    issue(OP_LW, 0, 30);
    repeat (6) @(posedge CLK);
    do_reset(1'b1);
    issue(OP_LUI, 0, 0);     drain();
    repeat (10) @(posedge CLK);
    do_reset(1'b1);
    issue(OP_R, 0, 0);       drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
